// File: rtl/edge_arb_pkg.sv
// Shared types for the edge-event arbiter: FSM state and edge polarity.
package edge_arb_pkg;

   typedef enum logic {IDLE, SEND} arb_state_t;

   typedef enum logic {EDGE_FALL = 1'b0, EDGE_RISE = 1'b1} edge_t;

endpackage

// File: rtl/edge_event_arbiter_if.sv
// Valid/ready event port: the arbiter drives channel and polarity, the consumer drives ready.
interface edge_event_arbiter_if #(
   parameter int unsigned N_CH = 4
);
   localparam int unsigned CH_W = $clog2(N_CH);

   logic            evt_valid;
   logic            evt_ready;
   logic [CH_W-1:0] evt_ch;
   logic            evt_rise;

   modport master (
      output evt_valid,
      output evt_ch,
      output evt_rise,
      input  evt_ready
   );

   modport slave (
      input  evt_valid,
      input  evt_ch,
      input  evt_rise,
      output evt_ready
   );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after last_i, wrapping N-1 -> 0.
module rr_arbiter #(
   parameter int unsigned N    = 4,
   parameter int unsigned CH_W = $clog2(N)
) (
   input  logic [N-1:0]    req_i,
   input  logic [CH_W-1:0] last_i,
   output logic            gnt_vld_o,
   output logic [CH_W-1:0] gnt_idx_o
);

   int unsigned idx;

   always_comb begin
      gnt_vld_o = 1'b0;
      gnt_idx_o = '0;
      idx       = 0;
      // Walk offsets 1..N so last_i itself is considered last.
      for (int unsigned k = 1; k <= N; k++) begin
         idx = (int'(last_i) + k) % N;
         if (!gnt_vld_o && req_i[idx]) begin
            gnt_vld_o = 1'b1;
            gnt_idx_o = CH_W'(idx);
         end
      end
   end

endmodule

// File: rtl/edge_event_arbiter.sv
// Per-channel rise/fall detectors latching pending events, served round-robin on one port.
module edge_event_arbiter
   import edge_arb_pkg::*;
#(
   parameter int unsigned N_CH = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_CH-1:0]             a_i,
   input  logic [N_CH-1:0]             en_i,
   input  logic                        ovf_clr_i,
   output logic                        ovf_o,
   edge_event_arbiter_if.master        evt
);

   localparam int unsigned CH_W = $clog2(N_CH);

   arb_state_t      state_q, state_d;
   logic [N_CH-1:0] prev_a_q;
   logic [N_CH-1:0] rise_pend_q, rise_pend_d;
   logic [N_CH-1:0] fall_pend_q, fall_pend_d;
   logic [N_CH-1:0] rise_det, fall_det, rise_clr, fall_clr;
   logic [CH_W-1:0] last_q, last_d;
   logic [CH_W-1:0] ch_q, ch_d;
   edge_t           edge_q, edge_d;
   logic            ovf_q, ovf_d, ovf_new;
   logic            gnt_vld, hs, load;
   logic [CH_W-1:0] gnt_idx;

   assign rise_det = ~prev_a_q & a_i & en_i;
   assign fall_det = prev_a_q & ~a_i & en_i;

   rr_arbiter #(
      .N    (N_CH),
      .CH_W (CH_W)
   ) u_rr (
      .req_i     (rise_pend_q | fall_pend_q),
      .last_i    (last_q),
      .gnt_vld_o (gnt_vld),
      .gnt_idx_o (gnt_idx)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (gnt_vld) state_d = SEND;
         SEND:    if (evt.evt_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      evt.evt_valid = (state_q == SEND);
      evt.evt_ch    = ch_q;
      evt.evt_rise  = (edge_q == EDGE_RISE);
      hs            = (state_q == SEND) && evt.evt_ready;
      load          = (state_q == IDLE) && gnt_vld;
   end

   always_comb begin
      rise_clr = '0;
      fall_clr = '0;
      if (hs) begin
         if (edge_q == EDGE_RISE) rise_clr[ch_q] = 1'b1;
         else                     fall_clr[ch_q] = 1'b1;
      end
      // A new edge on a bit being cleared this cycle re-arms it without overflow.
      rise_pend_d = (rise_pend_q & ~rise_clr) | rise_det;
      fall_pend_d = (fall_pend_q & ~fall_clr) | fall_det;
      ovf_new     = |(rise_det & rise_pend_q & ~rise_clr) |
                    |(fall_det & fall_pend_q & ~fall_clr);
      ovf_d       = (ovf_q & ~ovf_clr_i) | ovf_new;
      ch_d        = load ? gnt_idx : ch_q;
      edge_d      = edge_q;
      if (load) edge_d = rise_pend_q[gnt_idx] ? EDGE_RISE : EDGE_FALL;
      last_d      = hs ? ch_q : last_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_a_q    <= '0;
         rise_pend_q <= '0;
         fall_pend_q <= '0;
         last_q      <= CH_W'(N_CH - 1);
         ch_q        <= '0;
         edge_q      <= EDGE_FALL;
         ovf_q       <= 1'b0;
      end else begin
         prev_a_q    <= a_i;
         rise_pend_q <= rise_pend_d;
         fall_pend_q <= fall_pend_d;
         last_q      <= last_d;
         ch_q        <= ch_d;
         edge_q      <= edge_d;
         ovf_q       <= ovf_d;
      end
   end

   assign ovf_o = ovf_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed, table-driven checks of edge detection, round-robin order, overflow and reset.
module tb_edge_event_arbiter;

   localparam int unsigned N_CH = 4;

   typedef struct {
      logic [3:0] a;
      logic       rdy;
      logic       v;
      logic [1:0] ch;
      logic       r;
      logic       o;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] a_i = 4'b0001;
   logic [3:0] en_i = 4'b1111;
   logic       ovf_clr_i = 1'b0;
   logic       ovf_o;

   int n_tests = 0;
   int n_fail  = 0;

   edge_event_arbiter_if #(.N_CH(N_CH)) evt_if ();

   edge_event_arbiter #(.N_CH(N_CH)) dut (
      .clk       (clk),
      .rst       (rst),
      .a_i       (a_i),
      .en_i      (en_i),
      .ovf_clr_i (ovf_clr_i),
      .ovf_o     (ovf_o),
      .evt       (evt_if.master)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic v, input logic [1:0] ch, input logic r,
                        input logic o);
      n_tests++;
      if (evt_if.evt_valid !== v || ovf_o !== o ||
          (v && (evt_if.evt_ch !== ch || evt_if.evt_rise !== r))) begin
         n_fail++;
         $display("FAIL %s: got valid=%b ch=%0d rise=%b ovf=%b, want valid=%b ch=%0d rise=%b ovf=%b",
                  name, evt_if.evt_valid, evt_if.evt_ch, evt_if.evt_rise, ovf_o, v, ch, r, o);
      end
   endtask

   // Called at a negedge: drive, let one posedge pass, check, return at the next negedge.
   task automatic cyc(input string name, input logic [3:0] a, input logic rdy, input logic clr,
                      input logic v, input logic [1:0] ch, input logic r, input logic o);
      a_i              = a;
      evt_if.evt_ready = rdy;
      ovf_clr_i        = clr;
      @(posedge clk);
      #1;
      check(name, v, ch, r, o);
      @(negedge clk);
   endtask

   vec_t tbl[31];

   initial begin
      tbl[0]  = '{4'b0001, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
      tbl[1]  = '{4'b0001, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0};
      tbl[2]  = '{4'b0001, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0};
      tbl[3]  = '{4'b0001, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0};
      tbl[4]  = '{4'b0101, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0};
      tbl[5]  = '{4'b0101, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0};
      tbl[6]  = '{4'b0001, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0};
      tbl[7]  = '{4'b0001, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0};
      tbl[8]  = '{4'b0001, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0};
      tbl[9]  = '{4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0};
      tbl[10] = '{4'b0000, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0};
      tbl[11] = '{4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0};
      tbl[12] = '{4'b1111, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0};
      tbl[13] = '{4'b1111, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0};
      tbl[14] = '{4'b1111, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0};
      tbl[15] = '{4'b1111, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0};
      tbl[16] = '{4'b1111, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0};
      tbl[17] = '{4'b1111, 1'b1, 1'b1, 2'd3, 1'b1, 1'b0};
      tbl[18] = '{4'b1111, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0};
      tbl[19] = '{4'b1111, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0};
      tbl[20] = '{4'b1111, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0};
      tbl[21] = '{4'b0110, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0};
      tbl[22] = '{4'b0110, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0};
      tbl[23] = '{4'b1111, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0};
      tbl[24] = '{4'b1111, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0};
      tbl[25] = '{4'b1111, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0};
      tbl[26] = '{4'b1111, 1'b1, 1'b1, 2'd3, 1'b1, 1'b0};
      tbl[27] = '{4'b1111, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0};
      tbl[28] = '{4'b1111, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0};
      tbl[29] = '{4'b1111, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0};
      tbl[30] = '{4'b1111, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0};

      evt_if.evt_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_state", 1'b0, 2'd0, 1'b0, 1'b0);
      n_tests++;
      if (evt_if.evt_ch !== 2'd0 || evt_if.evt_rise !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got ch=%0d rise=%b, want ch=0 rise=0",
                  evt_if.evt_ch, evt_if.evt_rise);
      end

      rst = 1'b0;
      for (int i = 0; i < 31; i++) begin
         cyc($sformatf("vec%0d", i), tbl[i].a, tbl[i].rdy, 1'b0, tbl[i].v, tbl[i].ch, tbl[i].r,
             tbl[i].o);
      end

      // Overflow: ch1 toggles with the consumer stalled.
      cyc("ovf_prep0", 4'b1101, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
      cyc("ovf_prep1", 4'b1101, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0);
      cyc("ovf_prep2", 4'b1101, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
      cyc("ovf_rise1", 4'b1111, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
      cyc("ovf_fall1", 4'b1101, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0);
      cyc("ovf_rise2", 4'b1111, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) begin
         cyc($sformatf("ovf_hold%0d", i), 4'b1111, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1);
      end
      cyc("ovf_clear", 4'b1111, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0);
      cyc("ovf_clr_vs_new", 4'b1101, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1);
      cyc("ovf_hs_rise", 4'b1101, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
      cyc("ovf_fall_evt", 4'b1101, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1);
      cyc("ovf_hs_fall", 4'b1101, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
      cyc("ovf_clear2", 4'b1101, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);

      // Disabled channel: toggles are ignored, and enabling on a steady level adds nothing.
      en_i = 4'b0111;
      for (int i = 0; i < 4; i++) begin
         cyc($sformatf("en_off%0d", i), (i % 2 == 0) ? 4'b0101 : 4'b1101, 1'b1, 1'b0, 1'b0,
             2'd0, 1'b0, 1'b0);
      end
      cyc("en_off_settle", 4'b0101, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
      en_i = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         cyc($sformatf("en_on%0d", i), 4'b0101, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
      end

      // Reset while an event is presented and stalled.
      cyc("rst_rise3", 4'b1101, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
      cyc("rst_present", 4'b1101, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1, 1'b0);
      rst = 1'b1;
      #1;
      check("rst_async_drop", 1'b0, 2'd0, 1'b0, 1'b0);
      @(negedge clk);
      a_i = 4'b0000;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cyc($sformatf("rst_quiet%0d", i), 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
